// File: rtl/nx_fifo_flex_pkg.sv
// nx_fifo_flex_pkg: shared sizing helpers, pointer wrap increment and the
// overflow/underflow status struct used by the nx_fifo_flex slice.
package nx_fifo_flex_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } nx_flow_t;

    // Width able to hold 0..depth inclusive.
    function automatic int unsigned nx_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned nx_ptr_w(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Wraps at depth-1 so non-power-of-2 depths work.
    function automatic logic [31:0] nx_ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/nx_fifo_flex_ctrl.sv
// nx_fifo_flex_ctrl: data-less FIFO control (pointers, occupancy, flags,
// high watermark, registered overflow/underflow pulses).
// Ports:
//   i_clk, i_rst (sync, active high), i_wen, i_ren, i_clear (sync flush)
//   o_wa            accepted write this cycle (storage write enable)
//   o_wptr, o_rptr  storage pointers
//   o_empty, o_full, o_almost_full, o_almost_empty  flags from count
//   o_used_slots, o_free_slots, o_high_water       occupancy
//   o_overflow, o_underflow                        one-cycle pulses
// Optional: define NX_FIFO_FLEX_FLOW_ASSERT to enable SVA on the pulses.
module nx_fifo_flex_ctrl
    import nx_fifo_flex_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned AFULL_THRESH  = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned CW           = nx_cw(DEPTH),
    localparam int unsigned PW           = nx_ptr_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wen,
    input  logic          i_ren,
    input  logic          i_clear,
    output logic          o_wa,
    output logic [PW-1:0] o_wptr,
    output logic [PW-1:0] o_rptr,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_almost_full,
    output logic          o_almost_empty,
    output logic [CW-1:0] o_used_slots,
    output logic [CW-1:0] o_free_slots,
    output logic [CW-1:0] o_high_water,
    output logic          o_overflow,
    output logic          o_underflow
);

    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullC  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_THRESH);

    if (AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("nx_fifo_flex: AFULL_THRESH must not exceed DEPTH");
    end
    if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
        $error("nx_fifo_flex: AEMPTY_THRESH must be below DEPTH");
    end

    logic [PW-1:0] r_wptr, r_rptr, w_wptr_d, w_rptr_d;
    logic [CW-1:0] r_count, w_count_d, r_high_water, w_high_water_d;
    nx_flow_t      r_flow, w_flow_d;
    logic          w_wa, w_ra, w_empty, w_full;

    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == DepthC);
        // clear suppresses both transfers in its cycle
        w_wa    = i_wen & ~w_full & ~i_clear;
        w_ra    = i_ren & ~w_empty & ~i_clear;

        w_wptr_d       = r_wptr;
        w_rptr_d       = r_rptr;
        w_count_d      = r_count;
        w_high_water_d = r_high_water;
        if (i_clear) begin
            w_wptr_d       = '0;
            w_rptr_d       = '0;
            w_count_d      = '0;
            w_high_water_d = '0;
        end else begin
            if (w_wa) w_wptr_d = PW'(nx_ptr_inc(32'(r_wptr), DEPTH));
            if (w_ra) w_rptr_d = PW'(nx_ptr_inc(32'(r_rptr), DEPTH));
            w_count_d      = r_count + CW'(w_wa) - CW'(w_ra);
            w_high_water_d = (w_count_d > r_high_water) ? w_count_d : r_high_water;
        end

        w_flow_d.overflow  = i_wen & w_full & ~i_clear;
        w_flow_d.underflow = i_ren & w_empty & ~i_clear;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_high_water <= '0;
            r_flow       <= '0;
        end else begin
            r_wptr       <= w_wptr_d;
            r_rptr       <= w_rptr_d;
            r_count      <= w_count_d;
            r_high_water <= w_high_water_d;
            r_flow       <= w_flow_d;
        end
    end

    assign o_wa           = w_wa;
    assign o_wptr         = r_wptr;
    assign o_rptr         = r_rptr;
    assign o_empty        = w_empty;
    assign o_full         = w_full;
    assign o_almost_full  = (r_count >= AfullC);
    assign o_almost_empty = (r_count <= AemptyC);
    assign o_used_slots   = r_count;
    assign o_free_slots   = DepthC - r_count;
    assign o_high_water   = r_high_water;
    assign o_overflow     = r_flow.overflow;
    assign o_underflow    = r_flow.underflow;

`ifdef NX_FIFO_FLEX_FLOW_ASSERT
    a_no_overflow: assert property (@(posedge i_clk) !r_flow.overflow)
        else $error("nx_fifo_flex: overflow");
    a_no_underflow: assert property (@(posedge i_clk) !r_flow.underflow)
        else $error("nx_fifo_flex: underflow");
`endif

endmodule

// File: rtl/nx_fifo_flex.sv
// nx_fifo_flex: single-clock show-ahead FIFO, any DEPTH >= 2.
// Ports:
//   i_clk, i_rst (sync, active high), i_wen, i_ren, i_clear, i_wdata
//   o_rdata (head entry, zero-latency), o_empty, o_full, o_almost_full,
//   o_almost_empty, o_used_slots, o_free_slots, o_high_water,
//   o_overflow, o_underflow
// Optional: define NX_FIFO_FLEX_PARITY_EN to store even parity per entry and
// add o_parity_err; w_inj_mask is a force hook for corrupting written words.
module nx_fifo_flex
    import nx_fifo_flex_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned WIDTH         = 128,
    parameter int unsigned AFULL_THRESH  = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1,
    parameter int unsigned DATA_RESET    = 1,
    localparam int unsigned CW           = nx_cw(DEPTH),
    localparam int unsigned PW           = nx_ptr_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wen,
    input  logic             i_ren,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [CW-1:0]    o_used_slots,
    output logic [CW-1:0]    o_free_slots,
    output logic [CW-1:0]    o_high_water,
    output logic             o_overflow,
    output logic             o_underflow
`ifdef NX_FIFO_FLEX_PARITY_EN
    ,
    output logic             o_parity_err
`endif
);

`ifdef NX_FIFO_FLEX_PARITY_EN
    localparam int unsigned SW = WIDTH + 1;
`else
    localparam int unsigned SW = WIDTH;
`endif

    logic [SW-1:0] r_mem [DEPTH];
    logic [SW-1:0] w_wr_word, w_head;
    logic [PW-1:0] w_wptr, w_rptr;
    logic          w_wa, w_empty;

    nx_fifo_flex_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH),
        .AEMPTY_THRESH(AEMPTY_THRESH)
    ) u_ctrl (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wen         (i_wen),
        .i_ren         (i_ren),
        .i_clear       (i_clear),
        .o_wa          (w_wa),
        .o_wptr        (w_wptr),
        .o_rptr        (w_rptr),
        .o_empty       (w_empty),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_almost_empty(o_almost_empty),
        .o_used_slots  (o_used_slots),
        .o_free_slots  (o_free_slots),
        .o_high_water  (o_high_water),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

`ifdef NX_FIFO_FLEX_PARITY_EN
    logic [SW-1:0] w_inj_mask;
    assign w_inj_mask = '0;
    // Top bit holds even parity so the XOR of a clean stored word is 0.
    assign w_wr_word  = {^i_wdata, i_wdata} ^ w_inj_mask;
`else
    assign w_wr_word  = i_wdata;
`endif

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_wa && !i_rst) begin
            r_mem[w_wptr] <= w_wr_word;
        end
    end

    assign w_head  = r_mem[w_rptr];
    assign o_empty = w_empty;
    assign o_rdata = ((DATA_RESET != 0) && w_empty) ? '0 : w_head[WIDTH-1:0];

`ifdef NX_FIFO_FLEX_PARITY_EN
    assign o_parity_err = ~w_empty & (^w_head);
`endif

endmodule

// File: tb/tb_nx_fifo_flex.sv
// tb_nx_fifo_flex: scoreboard bench for nx_fifo_flex, exercising a DEPTH=5
// and a DEPTH=8 (AFULL_THRESH=6) instance; sel picks the active one.
module tb_nx_fifo_flex;

    logic       clk = 1'b0;
    logic       rst, sel;
    logic       s_wen, s_ren, s_clr;
    logic [7:0] s_wdata;

    logic [7:0] rd5, rd8;
    logic       emp5, full5, af5, ae5, ovf5, unf5;
    logic       emp8, full8, af8, ae8, ovf8, unf8;
    logic [2:0] used5, free5, hw5;
    logic [3:0] used8, free8, hw8;
    logic       perr5, perr8;

    logic [7:0] obs_rdata;
    logic [3:0] obs_used, obs_free, obs_hw;
    logic       obs_empty, obs_full, obs_af, obs_ae, obs_ovf, obs_unf, obs_perr;

    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];
    int         depth, af, hw;
    logic       e_ovf, e_unf, e_perr;
    logic [7:0] flip_mask;

    always #5 clk = ~clk;

    nx_fifo_flex #(
        .DEPTH(5), .WIDTH(8), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .DATA_RESET(1)
    ) u_dut5 (
        .i_clk(clk), .i_rst(rst), .i_wen(s_wen & ~sel), .i_ren(s_ren & ~sel),
        .i_clear(s_clr & ~sel), .i_wdata(s_wdata), .o_rdata(rd5), .o_empty(emp5),
        .o_full(full5), .o_almost_full(af5), .o_almost_empty(ae5), .o_used_slots(used5),
        .o_free_slots(free5), .o_high_water(hw5), .o_overflow(ovf5), .o_underflow(unf5)
`ifdef NX_FIFO_FLEX_PARITY_EN
        , .o_parity_err(perr5)
`endif
    );

    nx_fifo_flex #(
        .DEPTH(8), .WIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .DATA_RESET(1)
    ) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_wen(s_wen & sel), .i_ren(s_ren & sel),
        .i_clear(s_clr & sel), .i_wdata(s_wdata), .o_rdata(rd8), .o_empty(emp8),
        .o_full(full8), .o_almost_full(af8), .o_almost_empty(ae8), .o_used_slots(used8),
        .o_free_slots(free8), .o_high_water(hw8), .o_overflow(ovf8), .o_underflow(unf8)
`ifdef NX_FIFO_FLEX_PARITY_EN
        , .o_parity_err(perr8)
`endif
    );

`ifndef NX_FIFO_FLEX_PARITY_EN
    assign perr5 = 1'b0;
    assign perr8 = 1'b0;
`endif

    always_comb begin
        obs_rdata = sel ? rd8 : rd5;
        obs_used  = sel ? used8 : {1'b0, used5};
        obs_free  = sel ? free8 : {1'b0, free5};
        obs_hw    = sel ? hw8 : {1'b0, hw5};
        obs_empty = sel ? emp8 : emp5;
        obs_full  = sel ? full8 : full5;
        obs_af    = sel ? af8 : af5;
        obs_ae    = sel ? ae8 : ae5;
        obs_ovf   = sel ? ovf8 : ovf5;
        obs_unf   = sel ? unf8 : unf5;
        obs_perr  = sel ? perr8 : perr5;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        chk("used_slots", 32'(obs_used), n);
        chk("free_slots", 32'(obs_free), depth - n);
        chk("empty", 32'(obs_empty), 32'(n == 0));
        chk("full", 32'(obs_full), 32'(n == depth));
        chk("almost_full", 32'(obs_af), 32'(n >= af));
        chk("almost_empty", 32'(obs_ae), 32'(n <= 1));
        chk("high_water", 32'(obs_hw), hw);
        chk("overflow", 32'(obs_ovf), 32'(e_ovf));
        chk("underflow", 32'(obs_unf), 32'(e_unf));
        if (n == 0) chk("rdata_empty", 32'(obs_rdata), 0);
        else chk("rdata_head", 32'(obs_rdata), 32'(q[0]));
`ifdef NX_FIFO_FLEX_PARITY_EN
        chk("parity_err", 32'(obs_perr), 32'(e_perr));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        hw    = 0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        check_state();
    endtask

    // Drive one cycle, update the model from pre-edge state, check after the edge.
    task automatic cyc(input logic wen, input logic ren, input logic clr, input logic [7:0] d);
        int         n;
        logic       full_m, empty_m;
        logic [7:0] head;
        n       = q.size();
        full_m  = (n == depth);
        empty_m = (n == 0);
        s_wen   = wen;
        s_ren   = ren;
        s_clr   = clr;
        s_wdata = d;
        #1;
        if (clr) begin
            q.delete();
            hw    = 0;
            e_ovf = 1'b0;
            e_unf = 1'b0;
        end else begin
            e_ovf = wen & full_m;
            e_unf = ren & empty_m;
            if (ren && !empty_m) begin
                head = q.pop_front();
                chk("pop_data", 32'(obs_rdata), 32'(head));
            end
            if (wen && !full_m) q.push_back(d ^ flip_mask);
            if (q.size() > hw) hw = q.size();
        end
        @(posedge clk);
        #1;
        s_wen = 1'b0;
        s_ren = 1'b0;
        s_clr = 1'b0;
        check_state();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0; rst = 1'b0; s_wen = 1'b0; s_ren = 1'b0; s_clr = 1'b0; s_wdata = '0;
        depth = 5; af = 4; hw = 0; e_ovf = 1'b0; e_unf = 1'b0; e_perr = 1'b0;
        flip_mask = 8'h00;

        // DEPTH=5: fill, then overflow attempt
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h11 * i));
        cyc(1'b1, 1'b0, 1'b0, 8'h66);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Interleaved pop/push through the pointer wrap, then drain
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h66);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h77);
        cyc(1'b1, 1'b1, 1'b0, 8'h88);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h99);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);

        // Underflow, then simultaneous read/write on empty
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'hA5);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);

`ifdef NX_FIFO_FLEX_PARITY_EN
        force u_dut5.w_inj_mask = 9'h001;
        flip_mask = 8'h01;
        e_perr    = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h0F);
        release u_dut5.w_inj_mask;
        flip_mask = 8'h00;
        e_perr    = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
`endif

        // DEPTH=8, thresholds 6/1
        sel = 1'b1; depth = 8; af = 6;
        do_reset();
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);

        // Clear overrides a simultaneous write and read
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        cyc(1'b1, 1'b1, 1'b1, 8'h77);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset mid-stream, then behaves as fresh
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'hC3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
